// File: rtl/atm_keypad_entry.sv
// Keypad front end for the ATM: collects a two-digit PIN or amount, with edit keys,
// validation and an inactivity abort, and holds the last accepted value for the top level.
module atm_keypad_entry #(
   parameter int unsigned TIMEOUT_CYCLES = 250,
   parameter int unsigned PIN_MAX        = 14,
   parameter int unsigned AMT_MAX        = 63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [3:0] Pin,
   output logic       password_entered,
   output logic [5:0] amount,
   output logic       amount_ready,
   output logic       entry_error,
   output logic       timeout,
   output logic       busy,
   output logic [1:0] digit_count
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCollect = 2'd1;
   localparam logic [1:0] StDone    = 2'd2;

   localparam logic [3:0] KeyClear  = 4'd10;
   localparam logic [3:0] KeyBack   = 4'd11;
   localparam logic [3:0] KeyEnter  = 4'd12;
   localparam logic [3:0] KeyCancel = 4'd13;

   localparam int unsigned        CntW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0]    TmoMax = CntW'(TIMEOUT_CYCLES);
   localparam logic [6:0]         PinMax = 7'(PIN_MAX);
   localparam logic [6:0]         AmtMax = 7'(AMT_MAX);

   logic [1:0]      state_q, state_d;
   logic            mode_q, mode_d;
   logic [6:0]      acc_q, acc_d;
   logic [1:0]      dcnt_q, dcnt_d;
   logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [3:0]      pin_q, pin_d;
   logic            pw_q, pw_d;
   logic [5:0]      amt_q, amt_d;
   logic            ar_q, ar_d;
   logic            err_q, err_d;
   logic            tmo_q, tmo_d;
   logic            busy_q, busy_d;

   logic            key_accept;
   logic            enter_bad;
   logic [6:0]      acc_times10;

   assign key_accept  = key_valid && (key_code <= KeyCancel);
   assign acc_times10 = acc_q * 7'd10;
   assign enter_bad   = (dcnt_q == 2'd0) ||
                        (!mode_q && (acc_q > PinMax)) ||
                        (mode_q && (acc_q > AmtMax));

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      acc_d     = acc_q;
      dcnt_d    = dcnt_q;
      tmo_cnt_d = tmo_cnt_q;
      pin_d     = pin_q;
      pw_d      = pw_q;
      amt_d     = amt_q;
      ar_d      = ar_q;
      err_d     = 1'b0;
      tmo_d     = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StCollect;
               mode_d    = mode;
               acc_d     = 7'd0;
               dcnt_d    = 2'd0;
               tmo_cnt_d = '0;
               if (mode) begin
                  ar_d = 1'b0;
               end else begin
                  pw_d = 1'b0;
               end
            end
         end
         StCollect: begin
            if (key_accept) begin
               tmo_cnt_d = '0;
               if (key_code <= 4'd9) begin
                  // Third and later digits are dropped silently
                  if (dcnt_q < 2'd2) begin
                     acc_d  = acc_times10 + {3'b000, key_code};
                     dcnt_d = dcnt_q + 2'd1;
                  end
               end else begin
                  case (key_code)
                     KeyClear: begin
                        acc_d  = 7'd0;
                        dcnt_d = 2'd0;
                     end
                     KeyBack: begin
                        if (dcnt_q != 2'd0) begin
                           acc_d  = acc_q / 7'd10;
                           dcnt_d = dcnt_q - 2'd1;
                        end
                     end
                     KeyEnter: begin
                        if (enter_bad) begin
                           err_d  = 1'b1;
                           acc_d  = 7'd0;
                           dcnt_d = 2'd0;
                        end else if (!mode_q) begin
                           pin_d   = acc_q[3:0];
                           pw_d    = 1'b1;
                           state_d = StDone;
                        end else begin
                           amt_d   = acc_q[5:0];
                           ar_d    = 1'b1;
                           state_d = StDone;
                        end
                     end
                     default: state_d = StIdle;  // KeyCancel
                  endcase
               end
            end else begin
               tmo_cnt_d = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + CntW'(1);
               if (tmo_cnt_d == TmoMax) begin
                  tmo_d   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StCollect);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         mode_q    <= 1'b0;
         acc_q     <= 7'd0;
         dcnt_q    <= 2'd0;
         tmo_cnt_q <= '0;
         pin_q     <= 4'd0;
         pw_q      <= 1'b0;
         amt_q     <= 6'd0;
         ar_q      <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         acc_q     <= acc_d;
         dcnt_q    <= dcnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         pin_q     <= pin_d;
         pw_q      <= pw_d;
         amt_q     <= amt_d;
         ar_q      <= ar_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         busy_q    <= busy_d;
      end
   end

   assign Pin              = pin_q;
   assign password_entered = pw_q;
   assign amount           = amt_q;
   assign amount_ready     = ar_q;
   assign entry_error      = err_q;
   assign timeout          = tmo_q;
   assign busy             = busy_q;
   assign digit_count      = dcnt_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: PIN/amount entry, edits, errors, timeout and reset.
module tb_atm_keypad_entry;

   localparam logic [3:0] KClear  = 4'd10;
   localparam logic [3:0] KBack   = 4'd11;
   localparam logic [3:0] KEnter  = 4'd12;
   localparam logic [3:0] KCancel = 4'd13;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [3:0] pin;
   logic       password_entered;
   logic [5:0] amount;
   logic       amount_ready;
   logic       entry_error;
   logic       timeout;
   logic       busy;
   logic [1:0] digit_count;

   int n_tests = 0;
   int n_fail  = 0;

   atm_keypad_entry dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .mode            (mode),
      .key_valid       (key_valid),
      .key_code        (key_code),
      .Pin             (pin),
      .password_entered(password_entered),
      .amount          (amount),
      .amount_ready    (amount_ready),
      .entry_error     (entry_error),
      .timeout         (timeout),
      .busy            (busy),
      .digit_count     (digit_count)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic m);
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
   endtask

   task automatic press(input logic [3:0] code);
      key_valid = 1'b1;
      key_code  = code;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      tick();
      rst   = 1'b0;
      start = 1'b0;
      n_tests++;
      if ({pin, password_entered, amount, amount_ready, entry_error, timeout, busy, digit_count}
          !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got pin=%0d pw=%0b amt=%0d ar=%0b err=%0b tmo=%0b busy=%0b dc=%0d, want all 0",
                  pin, password_entered, amount, amount_ready, entry_error, timeout, busy,
                  digit_count);
      end
   endtask

   task automatic test_pin_entry();
      do_start(1'b0);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL pin_busy: got %0b want 1", busy); end
      press(4'd1);
      press(4'd0);
      n_tests++;
      if (digit_count !== 2'd2 || password_entered !== 1'b0) begin
         n_fail++;
         $display("FAIL pin_pre_enter: got dc=%0d pw=%0b want dc=2 pw=0", digit_count, password_entered);
      end
      press(KEnter);
      n_tests++;
      if (pin !== 4'd10 || password_entered !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL pin_enter: got pin=%0d pw=%0b busy=%0b want 10 1 0", pin, password_entered, busy);
      end
      // Now in DONE: this start must be dropped
      do_start(1'b1);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got busy=%0b want 0", busy); end
      do_start(1'b1);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_after_done: got busy=%0b want 1", busy); end
      press(KCancel);
      n_tests++;
      if (busy !== 1'b0 || pin !== 4'd10 || password_entered !== 1'b1) begin
         n_fail++;
         $display("FAIL pin_hold: got busy=%0b pin=%0d pw=%0b want 0 10 1", busy, pin, password_entered);
      end
   endtask

   task automatic test_reserved_pin();
      do_start(1'b0);
      n_tests++;
      if (password_entered !== 1'b0 || pin !== 4'd10) begin
         n_fail++;
         $display("FAIL pin_start_clear: got pw=%0b pin=%0d want 0 10", password_entered, pin);
      end
      press(4'd1);
      press(4'd5);
      press(KEnter);
      n_tests++;
      if (entry_error !== 1'b1 || digit_count !== 2'd0 || busy !== 1'b1 || password_entered !== 1'b0) begin
         n_fail++;
         $display("FAIL reserved_pin: got err=%0b dc=%0d busy=%0b pw=%0b want 1 0 1 0",
                  entry_error, digit_count, busy, password_entered);
      end
      press(4'd3);
      n_tests++;
      if (entry_error !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %0b want 0", entry_error); end
      press(KEnter);
      n_tests++;
      if (pin !== 4'd3 || password_entered !== 1'b1) begin
         n_fail++;
         $display("FAIL pin_retry: got pin=%0d pw=%0b want 3 1", pin, password_entered);
      end
      tick();
   endtask

   task automatic test_amount_edits();
      do_start(1'b1);
      press(4'd6);
      press(4'd4);
      press(KBack);
      n_tests++;
      if (digit_count !== 2'd1) begin n_fail++; $display("FAIL back_count: got %0d want 1", digit_count); end
      press(4'd2);
      press(4'd14);
      press(4'd9);
      n_tests++;
      if (digit_count !== 2'd2 || entry_error !== 1'b0) begin
         n_fail++;
         $display("FAIL third_digit: got dc=%0d err=%0b want 2 0", digit_count, entry_error);
      end
      press(KEnter);
      n_tests++;
      if (amount !== 6'd62 || amount_ready !== 1'b1 || password_entered !== 1'b1) begin
         n_fail++;
         $display("FAIL amount_62: got amt=%0d ar=%0b pw=%0b want 62 1 1", amount, amount_ready, password_entered);
      end
      tick();
      do_start(1'b1);
      press(4'd6);
      press(4'd4);
      press(KEnter);
      n_tests++;
      if (entry_error !== 1'b1 || amount !== 6'd62 || amount_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL amount_64: got err=%0b amt=%0d ar=%0b want 1 62 0", entry_error, amount, amount_ready);
      end
      press(KClear);
      press(KCancel);
   endtask

   task automatic test_timeout();
      logic early;
      early = 1'b0;
      do_start(1'b1);
      press(4'd5);
      for (int i = 1; i < 250; i++) begin
         tick();
         if (timeout !== 1'b0 || busy !== 1'b1) early = 1'b1;
      end
      n_tests++;
      if (early) begin n_fail++; $display("FAIL timeout_early: got early abort, want none before 250"); end
      tick();
      n_tests++;
      if (timeout !== 1'b1 || busy !== 1'b0 || amount_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_fire: got tmo=%0b busy=%0b ar=%0b want 1 0 0", timeout, busy, amount_ready);
      end
      tick();
      n_tests++;
      if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %0b want 0", timeout); end
   endtask

   task automatic test_reset_mid();
      do_start(1'b0);
      press(4'd7);
      rst       = 1'b1;
      key_valid = 1'b1;
      key_code  = KEnter;
      tick();
      rst       = 1'b0;
      key_valid = 1'b0;
      n_tests++;
      if ({pin, password_entered, amount, amount_ready, entry_error, timeout, busy, digit_count}
          !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got pin=%0d pw=%0b amt=%0d ar=%0b err=%0b tmo=%0b busy=%0b dc=%0d, want all 0",
                  pin, password_entered, amount, amount_ready, entry_error, timeout, busy,
                  digit_count);
      end
      tick();
      n_tests++;
      if (password_entered !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pw: got %0b want 0", password_entered); end
   endtask

   task automatic test_boundaries();
      press(4'd3);
      n_tests++;
      if (digit_count !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_key: got dc=%0d busy=%0b want 0 0", digit_count, busy);
      end
      do_start(1'b0);
      press(KBack);
      n_tests++;
      if (digit_count !== 2'd0 || entry_error !== 1'b0) begin
         n_fail++;
         $display("FAIL back_at_zero: got dc=%0d err=%0b want 0 0", digit_count, entry_error);
      end
      press(KEnter);
      n_tests++;
      if (entry_error !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL enter_empty: got err=%0b busy=%0b want 1 1", entry_error, busy);
      end
      // start with mode=1 while busy must not switch to amount entry
      do_start(1'b1);
      press(4'd1);
      press(4'd2);
      press(KEnter);
      n_tests++;
      if (pin !== 4'd12 || password_entered !== 1'b1 || amount_ready !== 1'b0 || amount !== 6'd0) begin
         n_fail++;
         $display("FAIL start_busy_ignored: got pin=%0d pw=%0b ar=%0b amt=%0d want 12 1 0 0",
                  pin, password_entered, amount_ready, amount);
      end
      tick();
      do_start(1'b0);
      press(4'd8);
      press(KCancel);
      n_tests++;
      if (busy !== 1'b0 || pin !== 4'd12 || password_entered !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel: got busy=%0b pin=%0d pw=%0b want 0 12 0", busy, pin, password_entered);
      end
   endtask

   initial begin
      test_reset();
      test_pin_entry();
      test_reserved_pin();
      test_amount_edits();
      test_timeout();
      test_reset_mid();
      test_boundaries();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
